// File: rtl/pin_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : pin_conditioner_if
// Description : Pin-side and control bundle for pin_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
interface pin_conditioner_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pins_i;
  logic [WIDTH-1:0] rise_en_i;
  logic [WIDTH-1:0] fall_en_i;
  logic [WIDTH-1:0] clear_i;
  logic [WIDTH-1:0] mask_i;
  logic [WIDTH-1:0] stable_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic [WIDTH-1:0] pending_o;
  logic             irq_o;

  modport master (
    output pins_i, rise_en_i, fall_en_i, clear_i, mask_i,
    input  stable_o, rise_o, fall_o, pending_o, irq_o
  );

  modport slave (
    input  pins_i, rise_en_i, fall_en_i, clear_i, mask_i,
    output stable_o, rise_o, fall_o, pending_o, irq_o
  );
endinterface
`default_nettype wire

// File: rtl/pin_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pin_conditioner
// Description : Synchronise, debounce and edge-detect raw pins; sticky
//               edge-pending flags with a maskable level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_conditioner #(
  parameter int WIDTH    = 32,
  parameter int DEBOUNCE = 16
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  pin_conditioner_if.slave   bus
);

  localparam int             c_CW      = (DEBOUNCE <= 1) ? 1 : $clog2(DEBOUNCE);
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;
  logic [WIDTH-1:0] w_set;

  // Per-bit run-length counter of synchronised samples that disagree with stable.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
      end else if (r_s2[gi] == r_stable[gi]) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_accept[gi] = (r_s2[gi] != r_stable[gi]) && (r_cnt == c_CNT_MAX);
  end : g_bit

  assign w_rise_next = w_accept &  r_s2 & ~r_stable;
  assign w_fall_next = w_accept & ~r_s2 &  r_stable;
  assign w_set       = (w_rise_next & bus.rise_en_i) | (w_fall_next & bus.fall_en_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_stable  <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_pending <= '0;
    end else begin
      r_s1      <= bus.pins_i;
      r_s2      <= r_s1;
      r_stable  <= (r_stable & ~w_accept) | (r_s2 & w_accept);
      r_rise    <= w_rise_next;
      r_fall    <= w_fall_next;
      // A set on the same edge as a clear wins.
      r_pending <= w_set | (r_pending & ~bus.clear_i);
    end
  end

  assign bus.stable_o  = r_stable;
  assign bus.rise_o    = r_rise;
  assign bus.fall_o    = r_fall;
  assign bus.pending_o = r_pending;
  assign bus.irq_o     = |(r_pending & bus.mask_i);

endmodule
`default_nettype wire

// File: tb/tb_pin_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_pin_conditioner
// Description : Directed and random checks of pin_conditioner against a
//               sample-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pin_conditioner;
  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst1_n = 1'b0;
  always #5 clk = ~clk;

  pin_conditioner_if #(.WIDTH(W)) if0 ();
  pin_conditioner_if #(.WIDTH(W)) if1 ();

  pin_conditioner #(.WIDTH(W), .DEBOUNCE(D)) u_dut (
    .clk_i (clk), .rst_ni(rst_n), .bus(if0.slave)
  );
  pin_conditioner #(.WIDTH(W), .DEBOUNCE(1)) u_dut1 (
    .clk_i (clk), .rst_ni(rst1_n), .bus(if1.slave)
  );

  int n_pass = 0;
  int n_checks = 0;

  // Reference model: a new level is accepted once the last D synchronised
  // samples all differ from the current stable level.
  logic [W-1:0] m_d1, m_d2, m_stable, m_rise, m_fall, m_pending;
  logic [W-1:0] hist[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_pending = '0;
    hist.delete();
  endtask

  task automatic model_edge();
    logic [W-1:0] s2;
    logic [W-1:0] acc;
    s2 = m_d2;
    hist.push_back(s2);
    if (hist.size() > D) void'(hist.pop_front());
    acc = '1;
    foreach (hist[j]) acc &= hist[j] ^ m_stable;
    if (hist.size() < D) acc = '0;
    m_rise    = acc & s2 & ~m_stable;
    m_fall    = acc & ~s2 & m_stable;
    m_pending = (m_rise & if0.rise_en_i) | (m_fall & if0.fall_en_i) | (m_pending & ~if0.clear_i);
    m_stable  = m_stable ^ acc;
    m_d2 = m_d1;
    m_d1 = if0.pins_i;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".stable"},  if0.stable_o,  m_stable);
    check({tag, ".rise"},    if0.rise_o,    m_rise);
    check({tag, ".fall"},    if0.fall_o,    m_fall);
    check({tag, ".pending"}, if0.pending_o, m_pending);
    check({tag, ".irq"},     {31'b0, if0.irq_o}, {31'b0, |(m_pending & if0.mask_i)});
  endtask

  task automatic step(input string tag);
    if (rst_n) model_edge();
    else model_reset();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    if0.pins_i = '0; if0.rise_en_i = '0; if0.fall_en_i = '0;
    if0.clear_i = '0; if0.mask_i = '0;
    if1.pins_i = 32'h1; if1.rise_en_i = 32'h1; if1.fall_en_i = '0;
    if1.clear_i = '0; if1.mask_i = 32'h1;
    model_reset();

    // Reset values
    #1;
    check_all("rst_hold");
    steps("rst_hold", 3);
    rst_n = 1'b1;
    steps("post_rst", 4);

    // Clean rise on bit 3, accepted at E5
    if0.rise_en_i[3] = 1'b1; if0.mask_i[3] = 1'b1; if0.pins_i[3] = 1'b1;
    steps("rise3_wait", 5);
    check("rise3_early", if0.stable_o, 32'h0);
    step("rise3_e5");
    check("rise3_stable", if0.stable_o, 32'h8);
    check("rise3_pulse",  if0.rise_o,   32'h8);
    check("rise3_pend",   if0.pending_o, 32'h8);
    check("rise3_irq",    {31'b0, if0.irq_o}, 32'h1);
    step("rise3_after");
    check("rise3_pulse_end", if0.rise_o, 32'h0);

    // Glitch rejection on bit 0 then a valid rise
    if0.pins_i[0] = 1'b1; steps("glitch_hi", 3);
    if0.pins_i[0] = 1'b0; steps("glitch_lo", 8);
    check("glitch_stable", if0.stable_o & 32'h1, 32'h0);
    if0.pins_i[0] = 1'b1; steps("glitch_ok", 5);
    check("glitch_wait", if0.stable_o & 32'h1, 32'h0);
    step("glitch_e5");
    check("glitch_accept", if0.rise_o & 32'h1, 32'h1);

    // Pending / clear / mask on bit 7
    if0.clear_i[3] = 1'b1; step("clr3");
    if0.clear_i[3] = 1'b0;
    if0.pins_i[7] = 1'b1; steps("b7_hi", 8);
    if0.fall_en_i[7] = 1'b1; if0.pins_i[7] = 1'b0; steps("b7_fall", 8);
    check("b7_pend", if0.pending_o & 32'h80, 32'h80);
    check("b7_nomask", {31'b0, if0.irq_o}, 32'h0);
    if0.mask_i[7] = 1'b1; #1;
    check("b7_mask_irq", {31'b0, if0.irq_o}, 32'h1);
    if0.fall_en_i[7] = 1'b0;
    step("b7_en_off");
    if0.clear_i[7] = 1'b1; step("b7_clear");
    check("b7_cleared", {31'b0, if0.irq_o}, 32'h0);
    if0.clear_i[7] = 1'b0;
    if0.fall_en_i[7] = 1'b1;
    if0.pins_i[7] = 1'b1; steps("b7_hi2", 8);
    if0.clear_i[7] = 1'b1; if0.pins_i[7] = 1'b0; steps("b7_fall_clr", 5);
    step("b7_set_wins");
    check("b7_set_wins", if0.pending_o & 32'h80, 32'h80);
    steps("b7_clr_held", 2);
    if0.clear_i = '0;

    // Reset mid-count
    if0.pins_i[5] = 1'b1; steps("mid_cnt", 4);
    #2 rst_n = 1'b0; model_reset(); #1;
    check_all("mid_rst");
    if0.pins_i = '0;
    steps("mid_rst_hold", 2);
    rst_n = 1'b1;
    steps("mid_rst_post", 8);

    // Enable gating: all bits toggle together
    if0.rise_en_i = '0; if0.fall_en_i = '1; if0.mask_i = '0;
    if0.pins_i = '1; steps("all_hi", 10);
    check("all_hi_nopend", if0.pending_o, 32'h0);
    if0.pins_i = '0; steps("all_lo", 10);
    check("all_lo_pend", if0.pending_o, 32'hFFFF_FFFF);
    if0.clear_i = '1; step("all_clr");
    if0.clear_i = '0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if0.pins_i    = if0.pins_i ^ ($urandom & $urandom & $urandom);
      if0.rise_en_i = $urandom;
      if0.fall_en_i = $urandom;
      if0.clear_i   = $urandom & $urandom & $urandom;
      if0.mask_i    = $urandom;
      step("rand");
    end

    // Pin held high through reset, DEBOUNCE=1 instance
    @(posedge clk); #1;
    rst1_n = 1'b1;
    @(posedge clk); #1;
    check("rh_e1_stable", if1.stable_o, 32'h0);
    @(posedge clk); #1;
    check("rh_e2_stable", if1.stable_o, 32'h0);
    @(posedge clk); #1;
    check("rh_e3_stable", if1.stable_o, 32'h1);
    check("rh_e3_rise",   if1.rise_o,   32'h1);
    check("rh_e3_pend",   if1.pending_o, 32'h1);
    @(posedge clk); #1;
    check("rh_e4_rise",   if1.rise_o,   32'h0);
    check("rh_e4_stable", if1.stable_o, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pin_conditioner.md
# pin_conditioner

Input-side companion to the Wishbone parallel port. It takes raw, asynchronous external pins and synchronises and debounces them, then drives the clean per-bit levels into the port's `parallel_i` input. It also produces per-bit edge pulses, sticky edge-pending flags and a maskable level interrupt, so software can react to pin changes without polling.

## Interface
- `WIDTH`, default 32: number of pins; must be ≥1.
- `DEBOUNCE`, default 16: consecutive synchronised samples needed to accept a new level; must be ≥1. Per-bit counter width is max(1, clog2(DEBOUNCE)).

- `clk_i` input 1: single clock; all state is on its rising edge.
- `rst_ni` input 1: reset. Asynchronous assert, active-low; every register clears to 0 while low.
- `pins_i` input WIDTH: raw external pins, asynchronous to `clk_i`.
- `stable_o` output WIDTH: debounced level; connects to the parallel port's `parallel_i`.
- `rise_o` output WIDTH: one-cycle pulse per bit on an accepted 0→1 transition.
- `fall_o` output WIDTH: one-cycle pulse per bit on an accepted 1→0 transition.
- `rise_en_i` input WIDTH: per bit, lets a rise set the pending flag.
- `fall_en_i` input WIDTH: per bit, lets a fall set the pending flag.
- `clear_i` input WIDTH: per-bit clear strobe for the pending flags (write-1-to-clear, sampled every cycle).
- `mask_i` input WIDTH: per-bit interrupt enable.
- `pending_o` output WIDTH: sticky per-bit edge flags.
- `irq_o` output 1: interrupt request, `|(pending_o & mask_i)`. This is combinational from registered `pending_o` and the `mask_i` input.

## Operation
Each bit is fully independent; there is no cross-bit state.
- **Synchroniser:** two flops, `s1 <= pins_i` then `s2 <= s1`. Both reset to 0.
- **Debounce counter `cnt`, evaluated every edge:**
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE-1`: `stable <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - Any sample where `s2` matches `stable` restarts the count, so glitches shorter than `DEBOUNCE` samples are discarded.
- **Edges:** on the same edge that updates `stable`, register `rise <= s2 & ~stable` or `fall <= ~s2 & stable`. Otherwise both register to 0. Each pulse is exactly one cycle wide and coincides with the first cycle of the new `stable_o` value.
- **Pending flags, per bit, evaluated every edge:**
  - `set = (rise_next & rise_en_i) | (fall_next & fall_en_i)`, where `rise_next`/`fall_next` are the values being registered this edge.
  - Update rule: `pending <= set | (pending & ~clear_i)`.
  - When set and clear coincide, set wins and the flag stays 1.
  - Clearing an already-0 flag has no effect.
  - Enables are sampled only at the moment of the edge. Disabling an enable later does not clear an existing flag.
- **Interrupt:** `irq_o` follows `pending_o` and `mask_i` with no added latency. Changing `mask_i` never alters `pending_o`.
- **Reset:** `stable_o`, `rise_o`, `fall_o`, `pending_o`, the counters and both sync stages are 0, so `irq_o` is 0.
  - A pin held high through reset is accepted as a rise `DEBOUNCE+2` edges after `rst_ni` deasserts. It sets pending if `rise_en_i` is high. This is intended behaviour.
  - Reset asserted mid-count discards the count; no partial pulse is produced.

## Timing
- **Accept latency:** the pin changes before edge E0 and stays constant. Then:
  - `s1` updates at E0 and `s2` at E1.
  - `stable_o`, `rise_o`/`fall_o` and `pending_o` update at E(DEBOUNCE+1), i.e. DEBOUNCE+2 rising edges in total.
  - `irq_o` follows in the same cycle as `pending_o`.
- **Minimum width:** a level must persist for DEBOUNCE consecutive `s2` samples to be accepted. With DEBOUNCE=1, any level present at two successive sync edges is accepted.
- **Clear latency:** `clear_i` high at edge E clears `pending_o` at E, unless a set occurs at E.
- **Pulse spacing:** consecutive accepted transitions on one bit are separated by at least DEBOUNCE cycles.
- **Counter range:** never exceeds DEBOUNCE-1 and never wraps.

## Test plan
- **Reset values:** WIDTH=32, DEBOUNCE=4, `pins_i`=0; pulse `rst_ni` low mid-run with the counters nonzero. → All outputs 0 during reset and after release; no pulses appear.
- **Clean rise:** DEBOUNCE=4; `pins_i[3]` 0→1 before E0; `rise_en_i[3]`=1, `mask_i[3]`=1. → `stable_o[3]`, `rise_o[3]` (one cycle), `pending_o[3]` and `irq_o` all go high at E5. `fall_o`=0; all other bits unaffected.
- **Glitch rejection:** DEBOUNCE=4; `pins_i[0]` high for 3 cycles, then low. → `stable_o[0]` stays 0 and no pulses occur. The bit is then held high for 4+ cycles. → Accepted at E5 relative to the second rise.
- **Pending/clear/mask:** after a fall on bit 7 with `fall_en_i[7]`=1:
  - `mask_i[7]`=0 → `pending_o[7]`=1 and `irq_o`=0. Setting the mask → `irq_o`=1 in the same cycle.
  - `clear_i[7]` pulse → `pending_o[7]`=0 and `irq_o`=0 at the next edge.
  - `clear_i[7]` held on the edge where a new fall is accepted → pending stays 1.
- **Enable gating and independence:** `rise_en_i`=0, `fall_en_i`=all ones; all 32 pins toggle 0→1→0, each held 10 cycles. → 32 rise pulses with no pending; then 32 fall pulses, giving `pending_o`=32'hFFFF_FFFF.
- **Reset-high pin:** `pins_i`=32'h0000_0001 held through reset; DEBOUNCE=1. → `stable_o[0]` and `rise_o[0]` go high at the 3rd edge after `rst_ni` rises.
